// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
// Holds the capture FSM state encoding and the counter width.
package pwm_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_in_cond.sv
// Conditions the asynchronous PWM input: 2-flop synchroniser, optional glitch
// filter (PWM_CAPTURE_FILTER_EN) and edge detect producing level/rise/fall.
module pwm_in_cond #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_d;
    logic w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic            r_filt;
    logic [FC_W-1:0] r_fcnt;

    // Level flips only after FILTER_LEN consecutive differing samples, so
    // rising and falling edges see the same delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (r_sync2 == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == FC_W'(FILTER_LEN - 1)) begin
            r_filt <= r_sync2;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + FC_W'(1);
        end
    end

    assign w_level = r_filt;
`else
    localparam int filter_len_unused = FILTER_LEN;

    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= w_level;
        end
    end

    assign level = w_level;
    assign rise  = w_level & ~r_level_d;
    assign fall  = ~w_level & r_level_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with no-edge timeout and stuck-level report.
// Build option PWM_CAPTURE_FILTER_EN adds a FILTER_LEN-cycle glitch filter.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT    = 32'd50_000_000,
    parameter int               FILTER_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_count,
    output logic [CNT_W-1:0] high_count,
    output logic             meas_valid,
    output logic             timeout,
    output logic             stuck_level
);

    // state | meaning
    // IDLE  | capture disabled, counters held at zero
    // ARM   | enabled, waiting for the first rise (partial period discarded)
    // HIGH  | inside the high phase, period and high counters running
    // LOW   | inside the low phase, next rise publishes a measurement

    logic w_level;
    logic w_rise;
    logic w_fall;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_period_count;
    logic [CNT_W-1:0] r_high_count;
    logic             r_meas_valid;
    logic             r_timeout;
    logic             r_stuck_level;

    logic w_at_limit;
    logic w_load;
    logic w_publish;
    logic w_tmo;
    logic w_clear;

    pwm_in_cond #(
        .FILTER_LEN (FILTER_LEN)
    ) u_in_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .level  (w_level),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_at_limit = (r_period_cnt == TIMEOUT);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_publish   = 1'b0;
        w_tmo       = 1'b0;
        w_clear     = 1'b0;
        if (!cap_en) begin
            w_state_nxt = IDLE;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = ARM;
                    w_clear     = 1'b1;
                end
                ARM: begin
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                        w_load      = 1'b1;
                    end else if (w_at_limit) begin
                        w_tmo = 1'b1;
                    end
                end
                HIGH: begin
                    if (w_at_limit) begin
                        w_tmo       = 1'b1;
                        w_state_nxt = ARM;
                    end else if (w_fall) begin
                        w_state_nxt = LOW;
                    end
                end
                LOW: begin
                    // A rise landing on the timeout cycle still counts as a measurement.
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                        w_load      = 1'b1;
                        w_publish   = 1'b1;
                    end else if (w_at_limit) begin
                        w_tmo       = 1'b1;
                        w_state_nxt = ARM;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_clear     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
        end else if (w_clear || w_tmo) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
        end else if (w_load) begin
            r_period_cnt <= CNT_W'(1);
            r_high_cnt   <= CNT_W'(1);
        end else begin
            r_period_cnt <= r_period_cnt + CNT_W'(1);
            if (r_state == HIGH && w_level) begin
                r_high_cnt <= r_high_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_count <= '0;
            r_high_count   <= '0;
            r_meas_valid   <= 1'b0;
            r_timeout      <= 1'b0;
            r_stuck_level  <= 1'b0;
        end else begin
            r_meas_valid <= w_publish;
            r_timeout    <= w_tmo;
            if (w_publish) begin
                r_period_count <= r_period_cnt;
                r_high_count   <= r_high_cnt;
            end else if (w_tmo) begin
                r_period_count <= '0;
                r_high_count   <= '0;
                r_stuck_level  <= w_level;
            end
        end
    end

    assign period_count = r_period_count;
    assign high_count   = r_high_count;
    assign meas_valid   = r_meas_valid;
    assign timeout      = r_timeout;
    assign stuck_level  = r_stuck_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: pulses are described as (period, high)
// pairs; a pulse-level model queues the expected events and a monitor checks them.
module tb_pwm_capture;

    localparam int TO = 1000;
    localparam int FL = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT  = 3 + FL;
    localparam int MINW = FL;
`else
    localparam int LAT  = 3;
    localparam int MINW = 2;
`endif

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        cap_en = 1'b0;
    logic        pwm_in = 1'b0;
    logic [31:0] period_count;
    logic [31:0] high_count;
    logic        meas_valid;
    logic        timeout;
    logic        stuck_level;

    pwm_capture #(
        .TIMEOUT    (32'(TO)),
        .FILTER_LEN (FL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cap_en       (cap_en),
        .pwm_in       (pwm_in),
        .period_count (period_count),
        .high_count   (high_count),
        .meas_valid   (meas_valid),
        .timeout      (timeout),
        .stuck_level  (stuck_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit is_to;
        int per;
        int hi;
        bit stk;
        int at;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    int          pend_v = 0;
    int          pend_t = 0;
    int          pend_h = 0;
    logic [31:0] hold_per = 0;
    logic [31:0] hold_hi  = 0;
    logic        hold_stk = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // A rise at the current drive cycle: it publishes the previous pulse if one
    // is pending, and a pulse longer than TO times out TO cycles after its rise.
    task automatic model_rise(input int t, input int h);
        if (pend_v != 0) begin
            exp_q.push_back('{is_to: 1'b0, per: pend_t, hi: pend_h, stk: 1'b0, at: cyc + LAT});
            hold_per = 32'(pend_t);
            hold_hi  = 32'(pend_h);
        end
        if (t <= TO) begin
            pend_v = 1;
            pend_t = t;
            pend_h = h;
        end else begin
            exp_q.push_back('{is_to: 1'b1, per: 0, hi: 0, stk: (TO < h), at: cyc + LAT + TO});
            hold_per = 0;
            hold_hi  = 0;
            hold_stk = (TO < h);
            pend_v   = 0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int t, input int h);
        model_rise(t, h);
        pwm_in = 1'b1;
        step(h);
        pwm_in = 1'b0;
        step(t - h);
    endtask

    task automatic enable_cap();
        cap_en = 1'b1;
        pend_v = 0;
        step(2);
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_period_hold"}, period_count, hold_per);
        check({tag, "_high_hold"}, high_count, hold_hi);
        check({tag, "_stuck_hold"}, stuck_level, hold_stk);
    endtask

    task automatic disable_cap(input string tag);
        cap_en = 1'b0;
        pend_v = 0;
        step(20);
        check_hold(tag);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (meas_valid || timeout)) begin
            check("pulse_overlap", meas_valid & timeout, 0);
            check("queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("event_is_timeout", timeout, e.is_to);
                check("event_cycle", cyc, e.at);
                check("period_count", period_count, e.per);
                check("high_count", high_count, e.hi);
                if (e.is_to) check("stuck_level", stuck_level, e.stk);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: sim time limit, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int h;

        step(3);
        check("rst_period", period_count, 0);
        check("rst_high", high_count, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_stuck", stuck_level, 0);
        rst_n = 1'b1;
        step(2);

        // Steady T=100 H=30
        enable_cap();
        repeat (6) pulse(100, 30);
        disable_cap("steady");

        // Random waveform
        enable_cap();
        for (int i = 0; i < 30; i++) begin
            t = int'($urandom_range(400, 2 * MINW));
            h = int'($urandom_range(t - MINW, MINW));
            pulse(t, h);
        end
        pulse(50, 20);
        disable_cap("random");

        // Rise on the timeout cycle, then timeouts with low and high stuck level
        enable_cap();
        pulse(100, 30);
        pulse(TO, 400);
        pulse(TO + 50, 20);
        pulse(120, 40);
        pulse(90, 30);
        pulse(TO + 50, TO + 20);
        pulse(70, 20);
        pulse(70, 20);
        disable_cap("boundary");

        // Input held high
        enable_cap();
        pulse(100, 30);
        model_rise(2 * TO, 2 * TO);
        pwm_in = 1'b1;
        step(TO + 100);
        cap_en = 1'b0;
        pend_v = 0;
        step(5);
        pwm_in = 1'b0;
        step(20);
        check_hold("held_high");

        // Disable mid-HIGH, then re-enable
        enable_cap();
        pulse(100, 30);
        pulse(150, 60);
        model_rise(200, 40);
        pwm_in = 1'b1;
        step(20);
        cap_en = 1'b0;
        pend_v = 0;
        step(10);
        pwm_in = 1'b0;
        step(30);
        check_hold("mid_high_off");
        enable_cap();
        pulse(110, 35);
        pulse(130, 45);
        pulse(90, 20);
        disable_cap("reenable");

        // Two-cycle glitch in the low phase of T=200 H=50
        enable_cap();
        pulse(200, 50);
`ifdef PWM_CAPTURE_FILTER_EN
        model_rise(200, 50);
`else
        model_rise(98, 50);
`endif
        pwm_in = 1'b1;
        step(50);
        pwm_in = 1'b0;
        step(48);
`ifndef PWM_CAPTURE_FILTER_EN
        model_rise(102, 2);
`endif
        pwm_in = 1'b1;
        step(2);
        pwm_in = 1'b0;
        step(100);
        pulse(200, 50);
        pulse(60, 20);
        disable_cap("glitch");

        // Reset asserted in the LOW phase
        enable_cap();
        pulse(100, 30);
        pulse(120, 40);
        model_rise(150, 60);
        pwm_in = 1'b1;
        step(60);
        pwm_in = 1'b0;
        step(20);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_period", period_count, 0);
        check("midrst_high", high_count, 0);
        check("midrst_meas_valid", meas_valid, 0);
        check("midrst_timeout", timeout, 0);
        check("midrst_stuck", stuck_level, 0);
        pend_v   = 0;
        hold_per = 0;
        hold_hi  = 0;
        hold_stk = 0;
        cap_en   = 1'b0;
        step(5);
        rst_n = 1'b1;
        step(5);
        enable_cap();
        pulse(100, 30);
        pulse(80, 25);
        pulse(50, 10);
        disable_cap("after_reset");

        step(LAT + 10);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
